// File: rtl/alien_gfx_pkg.sv
// Shared constants for the alien sprite renderer: sprite geometry, bitmap,
// colours and the drawer state encoding.
package alien_gfx_pkg;

  localparam int SPR_W_DEF = 8;
  localparam int SPR_H_DEF = 4;
  localparam int MASK_BITS = SPR_W_DEF * SPR_H_DEF;

  // Bit index is row*SPR_W + col; each byte below is one row, bit 0 = leftmost column.
  localparam logic [MASK_BITS-1:0] ALIEN_MASK = 32'hA5DB_7E3C;

  localparam logic [2:0] FG_COLOUR_DEF = 3'b010;
  localparam logic [2:0] BG_COLOUR_DEF = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic alien_mask_bit(input int unsigned idx);
    if (idx < MASK_BITS) begin
      return 1'(ALIEN_MASK >> idx);
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major pixel scanner over a SPR_W x SPR_H rectangle; wraps to zero after
// the last pixel so consecutive passes need no explicit clear.
module sprite_scan_counter
  import alien_gfx_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              i_clr,
  input  logic                              i_en,
  output logic [cnt_width(SPR_W*SPR_H)-1:0] o_cnt,
  output logic [cnt_width(SPR_W)-1:0]       o_col,
  output logic [cnt_width(SPR_H)-1:0]       o_row,
  output logic                              o_last
);

  localparam int CW = cnt_width(SPR_W);
  localparam int RW = cnt_width(SPR_H);
  localparam int NW = cnt_width(SPR_W * SPR_H);

  logic [NW-1:0] r_cnt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_end;
  logic          w_last;

  assign w_col_end = (r_col == CW'(SPR_W - 1));
  assign w_last    = w_col_end && (r_row == RW'(SPR_H - 1));

  // col/row are kept alongside cnt so no divider is needed for the mod/div split
  always_ff @(posedge clk) begin
    if (!resetn || i_clr) begin
      r_cnt <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_cnt <= '0;
        r_col <= '0;
        r_row <= '0;
      end else if (w_col_end) begin
        r_cnt <= r_cnt + NW'(1);
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_cnt <= r_cnt + NW'(1);
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = w_last;

endmodule

// File: rtl/alien_sprite_drawer.sv
// Renders the alien sprite into the VGA plot port: erases the previous
// rectangle, then draws the bitmap at the new position, one pixel per clock.
module alien_sprite_drawer
  import alien_gfx_pkg::*;
#(
  parameter int         SPR_W     = SPR_W_DEF,
  parameter int         SPR_H     = SPR_H_DEF,
  parameter logic [2:0] FG_COLOUR = FG_COLOUR_DEF,
  parameter logic [2:0] BG_COLOUR = BG_COLOUR_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] pos_x,
  input  logic [6:0] pos_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int CW = cnt_width(SPR_W);
  localparam int RW = cnt_width(SPR_H);
  localparam int NW = cnt_width(SPR_W * SPR_H);

  state_t        r_state;
  logic [7:0]    r_pos_x;
  logic [6:0]    r_pos_y;
  logic [7:0]    r_cur_x;
  logic [6:0]    r_cur_y;
  logic [7:0]    r_new_x;
  logic [6:0]    r_new_y;
  logic          r_drawn;
  logic [7:0]    r_vga_x;
  logic [6:0]    r_vga_y;
  logic [2:0]    r_colour;
  logic          r_plot;
  logic          r_busy;

  logic          w_cnt_clr;
  logic          w_cnt_en;
  logic [NW-1:0] w_cnt;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_last;
  logic          w_moved;
  logic          w_mask;
  logic [7:0]    w_erase_x;
  logic [6:0]    w_erase_y;
  logic [7:0]    w_draw_x;
  logic [6:0]    w_draw_y;

  sprite_scan_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_cnt  (w_cnt),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_last (w_last)
  );

  // Sampling stage is deliberately not reset so the first pass after reset uses the live position
  always_ff @(posedge clk) begin
    r_pos_x <= pos_x;
    r_pos_y <= pos_y;
  end

  assign w_cnt_clr = (r_state == S_IDLE);
  assign w_cnt_en  = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_moved   = !r_drawn || ({r_pos_x, r_pos_y} != {r_cur_x, r_cur_y});
  assign w_mask    = alien_mask_bit(32'(w_cnt));

  // Coordinates wrap modulo 256 / 128; clipping is left to the adapter
  assign w_erase_x = r_cur_x + 8'(w_col);
  assign w_erase_y = r_cur_y + 7'(w_row);
  assign w_draw_x  = r_new_x + 8'(w_col);
  assign w_draw_y  = r_new_y + 7'(w_row);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cur_x  <= 8'd0;
      r_cur_y  <= 7'd0;
      r_new_x  <= 8'd0;
      r_new_y  <= 7'd0;
      r_drawn  <= 1'b0;
      r_vga_x  <= 8'd0;
      r_vga_y  <= 7'd0;
      r_colour <= 3'd0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_plot <= 1'b0;
          r_busy <= 1'b0;
          if (w_moved) begin
            r_new_x <= r_pos_x;
            r_new_y <= r_pos_y;
            r_state <= r_drawn ? S_ERASE : S_DRAW;
          end
        end
        S_ERASE: begin
          r_plot   <= 1'b1;
          r_busy   <= 1'b1;
          r_colour <= BG_COLOUR;
          r_vga_x  <= w_erase_x;
          r_vga_y  <= w_erase_y;
          if (w_last) begin
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          r_plot   <= w_mask;
          r_busy   <= 1'b1;
          r_colour <= FG_COLOUR;
          r_vga_x  <= w_draw_x;
          r_vga_y  <= w_draw_y;
          if (w_last) begin
            r_cur_x <= r_new_x;
            r_cur_y <= r_new_y;
            r_drawn <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_plot  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vga_x  = r_vga_x;
  assign vga_y  = r_vga_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign busy   = r_busy;

endmodule

// File: doc/alien_sprite_drawer.md
# alien_sprite_drawer

Consumes the (x, y) position stream produced by the alien movement controller and renders the alien into the VGA framebuffer adapter. Whenever the position changes, it erases the sprite rectangle at the previously drawn position, then draws the sprite bitmap at the new position, one pixel per clock. It sits between the alien movement block and the VGA adapter's plot port.

## Interface

**Parameters**
- `SPR_W`, default 8: sprite width in pixels.
- `SPR_H`, default 4: sprite height in pixels.
- `FG_COLOUR`, default 3'b010: colour used for set bitmap pixels.
- `BG_COLOUR`, default 3'b000: colour used for erase.

**Ports**
- `clk`, in, 1: clock. Reset `resetn` is synchronous, active-low; clock is `clk`.
- `resetn`, in, 1: synchronous active-low reset.
- `pos_x`, in, 8: alien x position, level input from the movement block.
- `pos_y`, in, 7: alien y position, level input.
- `vga_x`, out, 8: pixel x to the VGA adapter.
- `vga_y`, out, 7: pixel y to the VGA adapter.
- `colour`, out, 3: pixel colour.
- `plot`, out, 1: write enable; the pixel is written on every cycle where `plot`=1.
- `busy`, out, 1: high while erasing or drawing.

## Operation

- **State**
  - FSM states: S_IDLE, S_ERASE, S_DRAW.
  - Internal registers: `cur_x`/`cur_y` (last drawn position), `new_x`/`new_y` (target), pixel counter `cnt` (0..SPR_W*SPR_H-1), and a `drawn` flag.
- **Reset**
  - State S_IDLE, `cnt`=0, `drawn`=0, `cur_*`=0, `new_*`=0.
  - All outputs 0: `vga_x`=0, `vga_y`=0, `colour`=0, `plot`=0, `busy`=0.
- **S_IDLE**
  - If `drawn`=0, or {`pos_x`,`pos_y`} ≠ {`cur_x`,`cur_y`}: latch `new_*` ← `pos_*` and clear `cnt`.
  - Then go to S_ERASE if `drawn`=1, otherwise S_DRAW.
  - Otherwise stay in S_IDLE with `plot`=0.
- **S_ERASE**
  - Scans `cnt` row-major: col = `cnt` mod SPR_W, row = `cnt` / SPR_W.
  - Emits `plot`=1 and `colour`=BG_COLOUR at (`cur_x`+col, `cur_y`+row) for every pixel of the rectangle.
  - At the last `cnt`: clear `cnt` and go to S_DRAW.
- **S_DRAW**
  - Same scan, at (`new_x`+col, `new_y`+row).
  - `plot` = `ALIEN_MASK[cnt]`, with `colour`=FG_COLOUR.
  - Cleared mask bits still consume one cycle with `plot`=0.
  - At the last `cnt`: `cur_*` ← `new_*`, `drawn` ← 1, go to S_IDLE.
- **Arithmetic**
  - x sum is truncated to 8 bits and y sum to 7 bits, so coordinates wrap modulo 256 and 128.
  - Off-screen clipping is the adapter's job.
- **Position changes while `busy`=1** are ignored. S_IDLE re-compares on return, so only the latest position is rendered and intermediate positions are skipped.
- **Reset mid-operation** aborts immediately.
  - `drawn` clears, so the stale image is not erased.
  - The next pass after reset is a draw-only pass at the current `pos_*`.

## Timing

- **Output registration:** all outputs are registered. The pixel for `cnt`=k appears on the outputs in the cycle after the FSM is at `cnt`=k.
- **Start latency:** position change sampled in S_IDLE at edge N → first erase pixel on the outputs after edge N+2 (fixed 2-cycle latency).
- **Erase pass:** exactly SPR_W*SPR_H output cycles, all with `plot`=1.
- **Draw pass:** exactly SPR_W*SPR_H output cycles, with popcount(`ALIEN_MASK`) plots.
- **Erase and draw are contiguous:** no gap cycle between them.
- **Move update:** a full update is 2*SPR_W*SPR_H cycles (64 with the defaults).
- **`busy`:**
  - Asserts in the cycle the first erase or draw pixel is output.
  - Deasserts in the cycle after the last pixel.
  - Is never high while `plot` is stale.
- **Back-to-back moves:** at least one S_IDLE cycle separates consecutive updates.

## Structure

- **Package `alien_gfx_pkg`:**
  - `SPR_W` and `SPR_H` defaults.
  - `ALIEN_MASK`, SPR_W*SPR_H bits, bit index row*SPR_W+col.
  - Colour constants.
  - State enum.
- **Sub-module `sprite_scan_counter`:**
  - Provides clear/enable, outputs col, row and last.
  - Reused by S_ERASE and S_DRAW.
- **Top level:** holds the FSM, the position registers and the output registers.

## Test plan

- **Reset then initial draw:** reset with `pos`=(34,15), release.
  - Draw-only pass: 32 cycles, no erase.
  - Plots exactly at the set bits of `ALIEN_MASK`, within x 34..41, y 15..18, with `colour`=3'b010.
  - Then `busy`=0.
- **Move right:** `pos_x` 34→35.
  - 32 erase plots, `colour`=0, covering x 34..41, y 15..18.
  - Immediately followed by a draw at x 35..42.
  - `cur_x`=35 afterwards.
- **Move down:** `pos_y` 15→19.
  - Erase of rows 15..18, then draw of rows 19..22.
  - 64 cycles total from first to last output pixel.
- **Change while busy:** `pos_x` steps 35→36→37 during the erase.
  - The current pass completes at 36.
  - One S_IDLE cycle later, a second pass erases 36 and draws at 37.
- **Wrap:** `pos`=(252,125).
  - `vga_x` sequence per row is 252,253,254,255,0,1,2,3.
  - `vga_y` rows are 125,126,127,0.
- **Reset mid-draw:** assert `resetn`=0 at `cnt`=10 of S_DRAW.
  - Next cycle: `plot`=0, `busy`=0, all outputs 0.
  - After release: a draw-only pass with no erase.
